sevenseg_display_controller: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 30 +++
 rtl/hex_to_sevenseg.sv | 11 +
 rtl/sevenseg_display_controller.sv | 156 +++++++++++++++
 tb/tb_sevenseg_display_controller.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment display controller.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low.
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark.
  localparam seg_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0..F.
  localparam seg_t HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/hex_to_sevenseg.sv
// Combinational 4-bit hex to active-low seven-segment glyph lookup.
module hex_to_sevenseg
  import sevenseg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/sevenseg_display_controller.sv
// Time-multiplexed hex display scanner for common-anode seven-segment LEDs.
// New values are latched into a shadow register on load and swapped into the
// displayed register only at frame boundaries, so a frame never tears.
// Optional build macro: SEVENSEG_LEADING_ZERO_BLANK_EN suppresses leading-zero digits.
module sevenseg_display_controller
  import sevenseg_pkg::*;
#(
  parameter int unsigned REFRESH_CNT = 100000,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned NUM_DIGITS  = 4
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CntW      = $clog2(REFRESH_CNT);
  localparam int unsigned IdxW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW      = 4 * NUM_DIGITS;
  localparam int unsigned ActiveMax = REFRESH_CNT - BLANK_CYC;

  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_CNT - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [ValW-1:0]       shadow_val_q, disp_val_q;
  logic [NUM_DIGITS-1:0] shadow_dp_q, disp_dp_q;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  logic                  slot_end;
  logic                  frame_end;
  logic                  slot_blank;
  logic [3:0]            cur_hex;
  logic                  cur_dp;
  logic                  cur_hidden;
  logic [NUM_DIGITS-1:0] an_sel;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [6:0]            cur_seg;

  assign slot_end   = (cnt_q == '0);
  assign frame_end  = slot_end && (idx_q == IdxMax);
  // Compare at 32 bits so a REFRESH_CNT that is a power of two cannot wrap.
  assign slot_blank = (32'(cnt_q) >= ActiveMax);

  // Slot timer: count down each slot, step the digit index when it expires.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      cnt_q <= CntMax;
      idx_q <= '0;
    end else if (slot_end) begin
      cnt_q <= CntMax;
      idx_q <= (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end else begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  // Shadow captures every load; display takes it (or a same-cycle load) at frame end.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
    end else begin
      if (load) begin
        shadow_val_q <= value;
        shadow_dp_q  <= dp_in;
      end
      if (frame_end) begin
        disp_val_q <= load ? value : shadow_val_q;
        disp_dp_q  <= load ? dp_in : shadow_dp_q;
      end
    end
  end

`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
  logic zero_above;

  // Digit i > 0 is hidden when it and everything above it are zero and its dp is off.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (disp_val_q[4*i +: 4] == 4'h0);
      lz_mask[i] = zero_above & ~disp_dp_q[i];
    end
  end
`else
  assign lz_mask = '0;
`endif

  // Select the digit, dp bit and anode pattern for the current index.
  always_comb begin
    cur_hex    = 4'h0;
    cur_dp     = 1'b0;
    cur_hidden = 1'b0;
    an_sel     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_hex    = disp_val_q[4*i +: 4];
        cur_dp     = disp_dp_q[i];
        cur_hidden = lz_mask[i];
        an_sel[i]  = 1'b0;
      end
    end
  end

  hex_to_sevenseg u_hex_to_sevenseg (
    .hex_i (cur_hex),
    .seg_o (cur_seg)
  );

  // Next output pattern: dark during blanking or for a suppressed digit.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (!slot_blank && !cur_hidden) begin
      an_d  = an_sel;
      seg_d = cur_seg;
      dp_d  = ~cur_dp;
    end
  end

  // Registered outputs; frame_done follows the frame-end cycle by one clock.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_end;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_display_controller.sv
// Scoreboard bench for sevenseg_display_controller (REFRESH_CNT=4, BLANK_CYC=1, 4 digits).
// The reference model tracks elapsed cycles since reset and derives slot and
// position arithmetically; expectations are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_sevenseg_display_controller;

  localparam int R = 4;
  localparam int B = 1;
  localparam int N = 4;
  localparam int FRAME = R * N;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  exp_t q[$];
  event chk_ev;
  bit   done = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state.
  int          m_t;
  logic [15:0] m_shadow, m_disp;
  logic [3:0]  m_sdp, m_ddp;

  sevenseg_display_controller #(
    .REFRESH_CNT (R),
    .BLANK_CYC   (B),
    .NUM_DIGITS  (N)
  ) dut (
    .clk        (clk),
    .clear      (clear),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic exp_t blank_exp();
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fd  = 1'b0;
    return e;
  endfunction

  // Expected outputs produced by the edge at which the scan sits at (slot, pos).
  function automatic exp_t predict(int slot, int pos);
    exp_t        e;
    logic [15:0] upper;
    bit          hide;
    e     = blank_exp();
    upper = m_disp >> (4 * slot);
    hide  = 1'b0;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    if (slot > 0 && upper == 16'h0 && !m_ddp[slot]) hide = 1'b1;
`endif
    if (pos >= B && !hide) begin
      e.an  = ~(4'b0001 << slot);
      e.seg = GLYPH[upper[3:0]];
      e.dp  = ~m_ddp[slot];
    end
    return e;
  endfunction

  function automatic void model_reset();
    m_t      = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_sdp    = '0;
    m_ddp    = '0;
  endfunction

  // Drive one clock of stimulus and queue the response expected after its edge.
  task automatic cycle(input logic clr, input logic ld, input logic [15:0] v,
                       input logic [3:0] d);
    exp_t e;
    int   slot, pos;
    bit   bnd;
    @(negedge clk);
    clear = clr;
    load  = ld;
    value = v;
    dp_in = d;
    if (clr) begin
      model_reset();
      e = blank_exp();
    end else begin
      slot = (m_t / R) % N;
      pos  = m_t % R;
      e    = predict(slot, pos);
      bnd  = (pos == R - 1) && (slot == N - 1);
      e.fd = bnd;
      if (bnd) begin
        m_disp = ld ? v : m_shadow;
        m_ddp  = ld ? d : m_sdp;
      end
      if (ld) begin
        m_shadow = v;
        m_sdp    = d;
      end
      m_t++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Idle until the next cycle to be driven sits at frame position p.
  task automatic run_to(input int p);
    while ((m_t % FRAME) != p) cycle(1'b0, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  // Assert clear between edges and check the outputs go dark without a clock.
  task automatic async_clear();
    @(negedge clk);
    #1;
    clear = 1'b1;
    load  = 1'b0;
    model_reset();
    q.push_back(blank_exp());
    ->chk_ev;
  endtask

  // Monitor: compare every registered output against the scoreboard.
  always begin
    exp_t e;
    @(posedge clk or chk_ev);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
        miscompares++;
        $display("FAIL outputs at %0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                 $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
    end
    if (done) begin
      if (q.size() != 0) begin
        miscompares++;
        $display("FAIL drain: got %0d pending expectations, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    logic [15:0] rv;
    model_reset();

    // Reset held, then first frame of zeros.
    repeat (3) cycle(1'b1, 1'b0, 16'h0, 4'h0);
    idle(5);
    cycle(1'b0, 1'b1, 16'h12AF, 4'b0010);
    idle(FRAME - 6);
    idle(FRAME);

    // Free run: frame_done spacing checked every cycle.
    idle(2 * FRAME);

    // Mid-frame load, then a boundary-cycle load that bypasses the shadow.
    run_to(4);
    cycle(1'b0, 1'b1, 16'h0003, 4'h0);
    run_to(FRAME - 1);
    cycle(1'b0, 1'b1, 16'h0007, 4'h0);
    idle(FRAME);

    // Randomised loads with a bias toward leading zeros.
    for (int i = 0; i < 6 * FRAME; i++) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 3));
      cycle(1'b0, ($urandom_range(0, 4) == 0), rv,
            ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom));
    end
    idle(FRAME);

    // Clear while digit 2 is lit, then restart from digit 0.
    run_to(2 * R + 2);
    async_clear();
    repeat (2) cycle(1'b1, 1'b0, 16'h0, 4'h0);
    idle(FRAME + 2);

    // Leading-zero patterns.
    cycle(1'b0, 1'b1, 16'h0050, 4'h0);
    run_to(0);
    idle(FRAME);
    cycle(1'b0, 1'b1, 16'h0000, 4'h0);
    run_to(0);
    idle(FRAME);
    cycle(1'b0, 1'b1, 16'h0000, 4'b0100);
    run_to(0);
    idle(FRAME);

    load = 1'b0;
    @(posedge clk);
    #3;
    done = 1'b1;
    ->chk_ev;
  end

endmodule
